// File: rtl/bit_block_generator_pkg.sv
// bit_block_generator_pkg: shared FSM encoding, widths and clamp limits
// for the block pattern generator, plus the length clamp helpers.
package bit_block_generator_pkg;

   localparam int DATA_W = 32;
   localparam int L_MIN  = 2;
   localparam int G_MIN  = 1;
   localparam int G_MAX  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      BUILD = 2'd2,
      EMIT  = 2'd3
   } state_t;

   typedef enum logic {
      PH_ONE = 1'b0,
      PH_GAP = 1'b1
   } phase_t;

   // Blocks shorter than two would merge with or vanish
   // from the downstream count, so they are widened.
   function automatic logic [2:0] clamp_len(input logic [2:0] len);
      return (len < 3'(L_MIN)) ? 3'(L_MIN) : len;
   endfunction

   function automatic logic [2:0] clamp_gap(input logic [2:0] gap);
      if (gap < 3'(G_MIN))
         return 3'(G_MIN);
      if (gap > 3'(G_MAX))
         return 3'(G_MAX);
      return gap;
   endfunction

endpackage

// File: rtl/bit_block_generator.sv
// bit_block_generator: builds a 32-bit word with block_num runs of ones,
// one bit per cycle LSB first, and emits it with a one-cycle data_enb.
// Ports: clk, rst_n (async low); req, block_num[3:0], block_len[2:0],
// gap_len[2:0] in; data[31:0], data_enb, exp_cnt[3:0], err, busy out.
import bit_block_generator_pkg::*;

module bit_block_generator #(
   parameter int FF_DLY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic [3:0]        block_num,
   input  logic [2:0]        block_len,
   input  logic [2:0]        gap_len,
   output logic [DATA_W-1:0] data,
   output logic              data_enb,
   output logic [3:0]        exp_cnt,
   output logic              err,
   output logic              busy
);

   // FF_DLY is a simulation-only register delay; registers here
   // update with zero delay, so the parameter has no effect.
   if (FF_DLY < 0) begin : g_ff_dly_neg
   end

   state_t            state;
   phase_t            phase;
   logic [3:0]        n_q;
   logic [2:0]        l_q;
   logic [2:0]        g_q;
   logic              err_q;
   logic [5:0]        pos;
   logic [2:0]        run;
   logic [3:0]        done;
   logic [DATA_W-1:0] build;
   logic [7:0]        need;

   // Max need is 15*7 + 14*4 = 161, so 8 bits never overflow.
   always_comb begin
      need = '0;
      if (n_q != 4'd0)
         need = 8'(n_q) * 8'(l_q)
              + (8'(n_q) - 8'd1) * 8'(g_q);
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         phase    <= PH_ONE;
         n_q      <= '0;
         l_q      <= '0;
         g_q      <= '0;
         err_q    <= 1'b0;
         pos      <= '0;
         run      <= '0;
         done     <= '0;
         build    <= '0;
         data     <= '0;
         data_enb <= 1'b0;
         exp_cnt  <= '0;
         err      <= 1'b0;
      end else begin
         data_enb <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req) begin
                  n_q   <= block_num;
                  l_q   <= clamp_len(block_len);
                  g_q   <= clamp_gap(gap_len);
                  build <= '0;
                  err_q <= 1'b0;
                  state <= CHECK;
               end
            end
            CHECK: begin
               pos   <= '0;
               phase <= PH_ONE;
               run   <= '0;
               done  <= '0;
               if (n_q == 4'd0) begin
                  err_q <= 1'b0;
                  state <= EMIT;
               end else if (need > 8'd32) begin
                  err_q <= 1'b1;
                  state <= EMIT;
               end else begin
                  state <= BUILD;
               end
            end
            BUILD: begin
               build[pos[4:0]] <= (phase == PH_ONE);
               pos             <= pos + 6'd1;
               if (phase == PH_ONE) begin
                  if (run == l_q - 3'd1) begin
                     run  <= '0;
                     done <= done + 4'd1;
                     // The last block ends the word: no trailing gap.
                     if (done + 4'd1 == n_q)
                        state <= EMIT;
                     else
                        phase <= PH_GAP;
                  end else begin
                     run <= run + 3'd1;
                  end
               end else begin
                  if (run == g_q - 3'd1) begin
                     run   <= '0;
                     phase <= PH_ONE;
                  end else begin
                     run <= run + 3'd1;
                  end
               end
            end
            EMIT: begin
               data_enb <= 1'b1;
               data     <= err_q ? '0 : build;
               exp_cnt  <= err_q ? 4'd0 : n_q;
               err      <= err_q;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_block_generator.sv
// tb_bit_block_generator: directed checks of the block pattern generator
// (latency, patterns, clamping, error path, busy drop, reset abort).
module tb_bit_block_generator;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic [3:0]  block_num;
   logic [2:0]  block_len;
   logic [2:0]  gap_len;
   logic [31:0] data;
   logic        data_enb;
   logic [3:0]  exp_cnt;
   logic        err;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;
   int strobes = 0;

   bit_block_generator #(.FF_DLY(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .block_num (block_num),
      .block_len (block_len),
      .gap_len   (gap_len),
      .data      (data),
      .data_enb  (data_enb),
      .exp_cnt   (exp_cnt),
      .err       (err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk)
      if (data_enb)
         strobes <= strobes + 1;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Independent reference: place each block by shifting a mask.
   function automatic int model_need(int n, int l, int g);
      if (n == 0)
         return 0;
      return n * l + (n - 1) * g;
   endfunction

   function automatic logic [31:0] model_word(int n, int l, int g);
      logic [31:0] w;
      int p;
      w = '0;
      p = 0;
      for (int b = 0; b < n; b++) begin
         w = w | (((32'd1 << l) - 32'd1) << p);
         p = p + l + g;
      end
      return w;
   endfunction

   // Issue one request; optionally keep req high (with other fields)
   // for 'hold' cycles after acceptance to check it is ignored.
   task automatic do_req(input string tag,
                         input logic [3:0] n,
                         input logic [2:0] l,
                         input logic [2:0] g,
                         input logic [31:0] e_data,
                         input logic [3:0] e_cnt,
                         input logic e_err,
                         input int e_lat,
                         input int hold);
      int lat;
      int s0;
      bit got;
      s0 = strobes;
      @(negedge clk);
      req = 1'b1;
      block_num = n;
      block_len = l;
      gap_len = g;
      @(posedge clk);
      #1;
      if (hold > 0) begin
         block_num = 4'd1;
         block_len = 3'd7;
         gap_len = 3'd4;
      end else begin
         req = 1'b0;
      end
      lat = 0;
      got = 1'b0;
      while (!got && lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
         if (lat >= hold)
            req = 1'b0;
         if (data_enb)
            got = 1'b1;
      end
      check({tag, ".lat"}, 32'(lat), 32'(e_lat));
      check({tag, ".data"}, data, e_data);
      check({tag, ".cnt"}, 32'(exp_cnt), 32'(e_cnt));
      check({tag, ".err"}, 32'(err), 32'(e_err));
      check({tag, ".busy"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check({tag, ".enb_drop"}, 32'(data_enb), 32'd0);
      check({tag, ".strobes"}, 32'(strobes - s0), 32'd1);
   endtask

   initial begin
      int s0;
      req = 1'b0;
      block_num = '0;
      block_len = '0;
      gap_len = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.data", data, 32'h0);
      check("rst.enb", 32'(data_enb), 32'd0);
      check("rst.cnt", 32'(exp_cnt), 32'd0);
      check("rst.err", 32'(err), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_req("n3", 4'd3, 3'd2, 3'd1, 32'h0000_00DB, 4'd3, 1'b0, 10, 0);
      do_req("n0", 4'd0, 3'd2, 3'd1, 32'h0, 4'd0, 1'b0, 2, 0);
      do_req("n11", 4'd11, 3'd2, 3'd1, 32'hDB6D_B6DB, 4'd11, 1'b0, 34, 0);
      do_req("n12", 4'd12, 3'd2, 3'd1, 32'h0, 4'd0, 1'b1, 2, 0);
      do_req("l7g4", 4'd2, 3'd7, 3'd4, 32'h0003_F87F, 4'd2, 1'b0, 20, 0);
      do_req("clamp_lo", 4'd2, 3'd1, 3'd0, 32'h0000_001B, 4'd2, 1'b0, 7, 0);
      do_req("clamp_g", 4'd2, 3'd2, 3'd7, 32'h0000_00C3, 4'd2, 1'b0, 10, 0);
      do_req("l3g2", 4'd4, 3'd3, 3'd2, 32'h0003_9CE7, 4'd4, 1'b0, 20, 0);
      do_req("busy_req", 4'd3, 3'd2, 3'd1, 32'h0000_00DB, 4'd3, 1'b0, 10, 6);
      do_req("after_busy", 4'd1, 3'd7, 3'd0, 32'h0000_007F, 4'd1, 1'b0, 9, 0);

      // Reset in the middle of BUILD aborts with no strobe.
      s0 = strobes;
      @(negedge clk);
      req = 1'b1;
      block_num = 4'd5;
      block_len = 3'd2;
      gap_len = 3'd1;
      @(posedge clk);
      #1;
      req = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst.data", data, 32'h0);
      check("mid_rst.enb", 32'(data_enb), 32'd0);
      check("mid_rst.cnt", 32'(exp_cnt), 32'd0);
      check("mid_rst.err", 32'(err), 32'd0);
      check("mid_rst.busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("mid_rst.no_strobe", 32'(strobes - s0), 32'd0);
      do_req("post_rst", 4'd1, 3'd2, 3'd1, 32'h0000_0003, 4'd1, 1'b0, 4, 0);

      for (int i = 0; i < 30; i++) begin
         int rn;
         int rl;
         int rg;
         int cl;
         int cg;
         int nd;
         bit bad;
         rn = $urandom_range(15, 0);
         rl = $urandom_range(7, 0);
         rg = $urandom_range(7, 0);
         cl = (rl < 2) ? 2 : rl;
         cg = (rg < 1) ? 1 : ((rg > 4) ? 4 : rg);
         nd = model_need(rn, cl, cg);
         bad = (nd > 32);
         do_req($sformatf("rnd%0d", i), 4'(rn), 3'(rl), 3'(rg),
                bad ? 32'h0 : model_word(rn, cl, cg),
                bad ? 4'd0 : 4'(rn), bad,
                bad ? 2 : 2 + nd, 0);
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
